// File: rtl/dc_skid_buf.sv
// Two-entry registered valid/ready buffer: a head slot feeding the consumer and a
// skid slot that catches one extra word, so in_rdy_o is a pure register output.
module dc_skid_buf #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld_i,
    input  logic [PW-1:0] in_data_i,
    output logic          in_rdy_o,
    output logic          out_vld_o,
    output logic [PW-1:0] out_data_o,
    input  logic          out_rdy_i
);

    logic          head_vld_q, head_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          push;
    logic          pop;

    assign in_rdy_o   = !skid_vld_q;
    assign out_vld_o  = head_vld_q;
    assign out_data_o = head_q;

    assign push = in_vld_i && !skid_vld_q;
    assign pop  = out_rdy_i && head_vld_q;

    // A word arriving while the head is popped goes straight into the head slot.
    always_comb begin
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        head_d     = head_q;
        skid_d     = skid_q;
        if (!head_vld_q || pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                head_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                head_vld_d = push;
                if (push) begin
                    head_d = in_data_i;
                end
            end
        end else if (push) begin
            skid_d     = in_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

endmodule

// File: rtl/dc_wide2narrow.sv
// Wide-to-narrow width converter: serialises S_W-bit words into M_W-bit lanes,
// carrying sof/eof and a last-lane index so frames may end mid-word.
module dc_wide2narrow #(
    parameter int  S_W       = 32,
    parameter int  M_W       = 8,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int RATIO     = S_W / M_W,
    localparam int CW        = $clog2(RATIO),
    localparam int SBW       = CW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_vld_i,
    input  logic [S_W-1:0] s_data_i,
    input  logic           s_sof,
    input  logic [SBW-1:0] s_eof_sb,
    output logic           s_rdy_o,
    output logic           m_vld_o,
    output logic [M_W-1:0] m_data_o,
    output logic           m_sof,
    output logic           m_eof,
    input  logic           m_rdy_i
);

    localparam int             PW       = S_W + 1 + SBW;
    localparam logic [CW-1:0]  CNT_LAST = CW'(RATIO - 1);

    function automatic logic [M_W-1:0] lane_sel(input logic [S_W-1:0] word,
                                                 input logic [CW-1:0]  idx);
        int pos;
        pos = LSB_FIRST ? int'(idx) : (RATIO - 1 - int'(idx));
        return word[pos*M_W +: M_W];
    endfunction

    logic [PW-1:0]  s_payload;
    logic [PW-1:0]  act_payload;
    logic           act_vld;
    logic           act_sof;
    logic [SBW-1:0] act_eof_sb;
    logic [S_W-1:0] act_data;
    logic           act_eof;
    logic [CW-1:0]  act_last;
    logic           act_pop;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_lane;
    logic           m_xfer;

    assign s_payload = {s_sof, s_eof_sb, s_data_i};

    dc_skid_buf #(
        .PW (PW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld_i   (s_vld_i),
        .in_data_i  (s_payload),
        .in_rdy_o   (s_rdy_o),
        .out_vld_o  (act_vld),
        .out_data_o (act_payload),
        .out_rdy_i  (act_pop)
    );

    assign act_sof    = act_payload[PW-1];
    assign act_eof_sb = act_payload[S_W +: SBW];
    assign act_data   = act_payload[S_W-1:0];
    assign act_eof    = act_eof_sb[CW];
    assign act_last   = act_eof_sb[CW-1:0];

    // A word ends at its final lane or, inside the closing word, at the eof lane;
    // any lanes past the eof lane are skipped without an output cycle.
    assign last_lane = (cnt_q == CNT_LAST) || (act_eof && (cnt_q == act_last));
    assign m_xfer    = act_vld && m_rdy_i;
    assign act_pop   = m_xfer && last_lane;

    always_comb begin
        cnt_d = cnt_q;
        if (m_xfer) begin
            cnt_d = last_lane ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Outputs are gated by the head valid so they read zero whenever it is empty.
    assign m_vld_o  = act_vld;
    assign m_data_o = act_vld ? lane_sel(act_data, cnt_q) : '0;
    assign m_sof    = act_vld && act_sof && (cnt_q == '0);
    assign m_eof    = act_vld && act_eof && (cnt_q == act_last);

endmodule

// File: tb/tb_dc_wide2narrow.sv
// Bench for dc_wide2narrow: table-driven vectors plus a queue scoreboard across
// LSB/MSB lane order and 32/8, 64/16, 16/8 ratios.
module tb_dc_wide2narrow;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eof;
        logic        wlast;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        logic        sof;
        logic [2:0]  eofsb;
        int          nl;
        logic [31:0] lanes;
        logic        exp_sof;
        logic        exp_eof;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_vld = 0, s_sof = 0, m_rdy = 0;
    logic [31:0] s_data = 0;
    logic [2:0]  s_eofsb = 0;
    logic        a_s_rdy, a_m_vld, a_m_sof, a_m_eof;
    logic [7:0]  a_m_data;
    logic        b_s_rdy, b_m_vld, b_m_sof, b_m_eof;
    logic [7:0]  b_m_data;

    logic        c_s_vld = 0, c_sof = 0, c_m_rdy = 0;
    logic [63:0] c_s_data = 0;
    logic [2:0]  c_eofsb = 0;
    logic        c_s_rdy, c_m_vld, c_m_sof, c_m_eof;
    logic [15:0] c_m_data;

    logic        d_s_vld = 0, d_sof = 0, d_m_rdy = 0;
    logic [15:0] d_s_data = 0;
    logic [1:0]  d_eofsb = 0;
    logic        d_s_rdy, d_m_vld, d_m_sof, d_m_eof;
    logic [7:0]  d_m_data;

    dc_wide2narrow #(.S_W(32), .M_W(8), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .s_vld_i(s_vld), .s_data_i(s_data), .s_sof(s_sof),
        .s_eof_sb(s_eofsb), .s_rdy_o(a_s_rdy), .m_vld_o(a_m_vld), .m_data_o(a_m_data),
        .m_sof(a_m_sof), .m_eof(a_m_eof), .m_rdy_i(m_rdy));

    dc_wide2narrow #(.S_W(32), .M_W(8), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .s_vld_i(s_vld), .s_data_i(s_data), .s_sof(s_sof),
        .s_eof_sb(s_eofsb), .s_rdy_o(b_s_rdy), .m_vld_o(b_m_vld), .m_data_o(b_m_data),
        .m_sof(b_m_sof), .m_eof(b_m_eof), .m_rdy_i(m_rdy));

    dc_wide2narrow #(.S_W(64), .M_W(16), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .s_vld_i(c_s_vld), .s_data_i(c_s_data), .s_sof(c_sof),
        .s_eof_sb(c_eofsb), .s_rdy_o(c_s_rdy), .m_vld_o(c_m_vld), .m_data_o(c_m_data),
        .m_sof(c_m_sof), .m_eof(c_m_eof), .m_rdy_i(c_m_rdy));

    dc_wide2narrow #(.S_W(16), .M_W(8), .LSB_FIRST(1'b1)) u_d (
        .clk(clk), .rst_n(rst_n), .s_vld_i(d_s_vld), .s_data_i(d_s_data), .s_sof(d_sof),
        .s_eof_sb(d_eofsb), .s_rdy_o(d_s_rdy), .m_vld_o(d_m_vld), .m_data_o(d_m_data),
        .m_sof(d_m_sof), .m_eof(d_m_eof), .m_rdy_i(d_m_rdy));

    int   checks = 0;
    int   failures = 0;
    ent_t qa[$], qb[$], qc[$], qd[$];
    int   occ = 0;
    logic stall = 0;
    logic [7:0] stall_data = 0;
    logic stall_sof = 0, stall_eof = 0;
    bit   a_done = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pop_chk(input string name, inout ent_t q[$], input logic [15:0] data,
                           input logic sof, input logic eof, output ent_t e);
        e = '{default: '0};
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL %s_unexpected: got lane %0h expected no lane at %0t", name, data, $time);
        end else begin
            e = q.pop_front();
            if (data !== e.data || sof !== e.sof || eof !== e.eof) begin
                failures++;
                $display("FAIL %s_lane: got %0h sof%0b eof%0b expected %0h sof%0b eof%0b at %0t",
                         name, data, sof, eof, e.data, e.sof, e.eof, $time);
            end
        end
    endtask

    // Expected lanes for the 32/8 pair; qa gets the LSB-first order only when asked.
    task automatic push_ab(input logic [31:0] w, input logic sof, input logic [2:0] eofsb,
                           input bit to_a);
        int   nl;
        ent_t e;
        nl = eofsb[2] ? int'(eofsb[1:0]) + 1 : 4;
        for (int i = 0; i < nl; i++) begin
            e.sof   = sof && (i == 0);
            e.eof   = eofsb[2] && (i == nl - 1);
            e.wlast = (i == nl - 1);
            e.data  = {8'h0, w[(3-i)*8 +: 8]};
            qb.push_back(e);
            e.data  = {8'h0, w[i*8 +: 8]};
            if (to_a) qa.push_back(e);
        end
    endtask

    task automatic send_ab(input logic [31:0] w, input logic sof, input logic [2:0] eofsb,
                           output int cyc);
        bit acc;
        acc = 0;
        cyc = 0;
        s_vld = 1; s_data = w; s_sof = sof; s_eofsb = eofsb;
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            acc = a_s_rdy;
            @(posedge clk); #1;
            cyc++;
        end
        s_vld = 0;
        if (!acc) chk("send_ab_timeout", 0, 1);
    endtask

    // Monitors: sample on the falling edge, inputs move 1 ns after the rising edge.
    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            occ = 0;
            stall = 0;
        end else begin
            if (stall) begin
                chk("hold_vld", a_m_vld, 1);
                chk("hold_data", a_m_data, stall_data);
                chk("hold_flags", {a_m_sof, a_m_eof}, {stall_sof, stall_eof});
            end
            chk("s_rdy_vs_occupancy", a_s_rdy, occ < 2);
            if (s_vld && a_s_rdy) occ++;
            if (a_m_vld && m_rdy) begin
                pop_chk("A", qa, {8'h0, a_m_data}, a_m_sof, a_m_eof, e);
                if (e.wlast) occ--;
            end
            stall = a_m_vld && !m_rdy;
            stall_data = a_m_data; stall_sof = a_m_sof; stall_eof = a_m_eof;
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (rst_n) begin
            if (b_s_rdy !== a_s_rdy) chk("B_s_rdy", b_s_rdy, a_s_rdy);
            if (b_m_vld && m_rdy) pop_chk("B", qb, {8'h0, b_m_data}, b_m_sof, b_m_eof, e);
            if (c_m_vld && c_m_rdy) pop_chk("C", qc, c_m_data, c_m_sof, c_m_eof, e);
            if (d_m_vld && d_m_rdy) pop_chk("D", qd, {8'h0, d_m_data}, d_m_sof, d_m_eof, e);
        end
    end

    task automatic run_c(input int nw);
        logic [63:0] w;
        logic        sof;
        logic [2:0]  eofsb;
        bit          acc;
        int          nl;
        ent_t        e;
        for (int k = 0; k < nw; k++) begin
            w = {$urandom, $urandom};
            sof = 1'($urandom);
            eofsb = ($urandom_range(0, 3) == 0) ? {1'b1, 2'($urandom)} : 3'b000;
            c_s_vld = 1; c_s_data = w; c_sof = sof; c_eofsb = eofsb;
            acc = 0;
            for (int t = 0; t < 500 && !acc; t++) begin
                c_m_rdy = 1'($urandom);
                @(negedge clk);
                acc = c_s_rdy;
                @(posedge clk); #1;
            end
            c_s_vld = 0;
            if (!acc) chk("C_send_timeout", 0, 1);
            nl = eofsb[2] ? int'(eofsb[1:0]) + 1 : 4;
            for (int i = 0; i < nl; i++) begin
                e.data = w[i*16 +: 16]; e.sof = sof && (i == 0);
                e.eof = eofsb[2] && (i == nl - 1); e.wlast = (i == nl - 1);
                qc.push_back(e);
            end
        end
        c_m_rdy = 1;
        for (int t = 0; t < 200 && qc.size() != 0; t++) @(posedge clk);
        chk("C_drained", qc.size(), 0);
    endtask

    task automatic run_d(input int nw);
        logic [15:0] w;
        logic        sof;
        logic [1:0]  eofsb;
        bit          acc;
        int          nl;
        ent_t        e;
        for (int k = 0; k < nw; k++) begin
            w = 16'($urandom);
            sof = 1'($urandom);
            eofsb = ($urandom_range(0, 2) == 0) ? {1'b1, 1'($urandom)} : 2'b00;
            d_s_vld = 1; d_s_data = w; d_sof = sof; d_eofsb = eofsb;
            acc = 0;
            for (int t = 0; t < 500 && !acc; t++) begin
                d_m_rdy = 1'($urandom);
                @(negedge clk);
                acc = d_s_rdy;
                @(posedge clk); #1;
            end
            d_s_vld = 0;
            if (!acc) chk("D_send_timeout", 0, 1);
            nl = eofsb[1] ? int'(eofsb[0]) + 1 : 2;
            for (int i = 0; i < nl; i++) begin
                e.data = {8'h0, w[i*8 +: 8]}; e.sof = sof && (i == 0);
                e.eof = eofsb[1] && (i == nl - 1); e.wlast = (i == nl - 1);
                qd.push_back(e);
            end
        end
        d_m_rdy = 1;
        for (int t = 0; t < 200 && qd.size() != 0; t++) @(posedge clk);
        chk("D_drained", qd.size(), 0);
    endtask

    initial begin
        vec_t tbl[7];
        int   total;
        int   cyc;
        ent_t e;

        tbl[0] = '{32'h44332211, 1'b1, 3'b111, 4, 32'h44332211, 1'b1, 1'b1};
        tbl[1] = '{32'h03020100, 1'b1, 3'b000, 4, 32'h03020100, 1'b1, 1'b0};
        tbl[2] = '{32'h07060504, 1'b0, 3'b111, 4, 32'h07060504, 1'b0, 1'b1};
        tbl[3] = '{32'hDDCCBBAA, 1'b1, 3'b101, 2, 32'h0000BBAA, 1'b1, 1'b1};
        tbl[4] = '{32'h000000EE, 1'b1, 3'b100, 1, 32'h000000EE, 1'b1, 1'b1};
        tbl[5] = '{32'h99887766, 1'b0, 3'b011, 4, 32'h99887766, 1'b0, 1'b0};
        tbl[6] = '{32'h55443322, 1'b0, 3'b110, 3, 32'h00443322, 1'b0, 1'b1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_vld", a_m_vld, 0);
        chk("rst_m_data", a_m_data, 0);
        chk("rst_m_flags", {a_m_sof, a_m_eof}, 2'b00);
        chk("rst_s_rdy", a_s_rdy, 1);
        chk("rst_C_s_rdy", c_s_rdy, 1);
        chk("rst_D_m_vld", d_m_vld, 0);
        rst_n = 1;
        m_rdy = 1;
        @(posedge clk); #1;

        // Table vectors back-to-back at full rate: lane stream must be gapless.
        total = 0;
        foreach (tbl[i]) total += tbl[i].nl;
        fork
            begin
                foreach (tbl[i]) begin
                    send_ab(tbl[i].data, tbl[i].sof, tbl[i].eofsb, cyc);
                    if (i < 2) chk($sformatf("first_try_accept_%0d", i), cyc, 1);
                    for (int l = 0; l < tbl[i].nl; l++) begin
                        e.data  = {8'h0, tbl[i].lanes[l*8 +: 8]};
                        e.sof   = tbl[i].exp_sof && (l == 0);
                        e.eof   = tbl[i].exp_eof && (l == tbl[i].nl - 1);
                        e.wlast = (l == tbl[i].nl - 1);
                        qa.push_back(e);
                    end
                    push_ab(tbl[i].data, tbl[i].sof, tbl[i].eofsb, 1'b0);
                end
            end
            begin
                bit seen;
                seen = 0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = a_m_vld;
                end
                chk("first_lane_seen", seen, 1);
                for (int k = 1; k < total; k++) begin
                    @(negedge clk);
                    chk("no_gap", a_m_vld, 1);
                end
                @(negedge clk);
                chk("idle_after_table", a_m_vld, 0);
            end
        join
        chk("table_drained", qa.size(), 0);
        @(posedge clk); #1;

        // Random source gaps with backpressure, alongside the other ratios.
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [31:0] w;
                    logic        sof;
                    logic [2:0]  eofsb;
                    w = $urandom;
                    sof = 1'($urandom);
                    eofsb = ($urandom_range(0, 3) == 0) ? {1'b1, 2'($urandom)} : 3'b000;
                    send_ab(w, sof, eofsb, cyc);
                    push_ab(w, sof, eofsb, 1'b1);
                    if ($urandom_range(0, 1) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                a_done = 1;
            end
            begin
                int n;
                n = 0;
                while (!(a_done && qa.size() == 0) && n < 5000) begin
                    m_rdy = (n < 40) ? (n % 2 == 0) : 1'($urandom);
                    @(posedge clk); #1;
                    n++;
                end
                chk("bp_phase_finished", n < 5000, 1);
                m_rdy = 1;
            end
            run_c(30);
            run_d(30);
        join
        chk("bp_A_drained", qa.size(), 0);
        chk("bp_B_drained", qb.size(), 0);

        // Reset two lanes into a word, then a fresh frame.
        m_rdy = 1;
        send_ab(32'h44332211, 1'b1, 3'b111, cyc);
        push_ab(32'h44332211, 1'b1, 3'b111, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("midrst_m_vld", a_m_vld, 0);
        chk("midrst_m_data", a_m_data, 0);
        chk("midrst_m_flags", {a_m_sof, a_m_eof}, 2'b00);
        chk("midrst_s_rdy", a_s_rdy, 1);
        chk("midrst_lanes_left", qa.size(), 2);
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("postrst_s_rdy", a_s_rdy, 1);
        chk("postrst_m_vld", a_m_vld, 0);
        send_ab(32'hA1B2C3D4, 1'b1, 3'b111, cyc);
        push_ab(32'hA1B2C3D4, 1'b1, 3'b111, 1'b1);
        @(negedge clk);
        chk("postrst_lane0", {a_m_vld, a_m_data, a_m_sof}, {1'b1, 8'hD4, 1'b1});
        for (int t = 0; t < 50 && qa.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("final_A_drained", qa.size(), 0);
        chk("final_B_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
